// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RISC-V control path: opcodes, FSM states, datapath mux selects.
// Latency: none (constants and types only).
// Backpressure: none.
package riscv_pkg;

    // Opcode field values the sequencer understands
    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_B      = 7'h63;
    localparam logic [6:0] OP_S      = 7'h23;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_JAL    = 7'h6F;

    // Sequencer states; encodings are visible on the debug port
    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC     = 4'd3,
        S_ALU_WB   = 4'd4,
        S_MEM_ADDR = 4'd5,
        S_MEM_RD   = 4'd6,
        S_MEM_WB   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    // ALU operation classes
    localparam logic [2:0] ALU_R     = 3'b000;
    localparam logic [2:0] ALU_I     = 3'b001;
    localparam logic [2:0] ALU_U     = 3'b010;
    localparam logic [2:0] ALU_B     = 3'b011;
    localparam logic [2:0] ALU_S     = 3'b101;
    localparam logic [2:0] ALU_ADD   = 3'b110;
    localparam logic [2:0] ALU_J     = 3'b111;

    // ALU operand A select
    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_RS1   = 2'b01;
    localparam logic [1:0] SRC_A_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;

    // Register writeback source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request has been stalled and flags the last allowed stall cycle.
// Latency: expired is combinational from the current count and count_en.
// Backpressure: none; TIMEOUT_CYCLES = 0 disables expiry.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_W        = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int               LIM   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(LIM);

    logic [TIMER_W-1:0] count;

    // Stall counter: cleared whenever not stalling, saturates rather than wrapping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // The stall that would bring the count to the limit is the one that trips the trap
    assign expired = (TIMEOUT_CYCLES != 0) && count_en && (count == LIMIT);

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle RISC-V sequencer stepping the shared datapath through fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction with zero-wait memory, +1 per memory wait cycle.
// Backpressure: stalls in FETCH/MEM_RD/MEM_WR until Mem_Ready_i; traps after TIMEOUT_CYCLES stalled cycles.
module multi_cycle_control
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_W        = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] OP_i,
    input  logic       Mem_Ready_i,
    output logic       PC_Write_o,
    output logic       Branch_o,
    output logic       PC_Src_o,
    output logic       I_or_D_o,
    output logic       Mem_Read_o,
    output logic       Mem_Write_o,
    output logic       IR_Write_o,
    output logic [1:0] Mem_to_Reg_o,
    output logic       Reg_Write_o,
    output logic [1:0] ALU_Src_A_o,
    output logic [1:0] ALU_Src_B_o,
    output logic [2:0] ALU_Op_o,
    output logic       Instr_Done_o,
    output logic       Illegal_o,
    output logic       Bus_Err_o,
    output logic [3:0] State_o
);

    state_e state;
    logic   illegal_q;
    logic   bus_err_q;
    logic   in_wait;
    logic   stall;
    logic   expired;

    assign in_wait = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign stall   = in_wait && !Mem_Ready_i;

    // Any non-stall cycle (ready, or not in a wait state) restarts the count, which also covers state entry
    mem_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMER_W        (TIMER_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (!stall),
        .count_en (stall),
        .expired  (expired)
    );

    // State sequencing plus the sticky trap-cause flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_INIT;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            case (state)
                S_INIT:     state <= S_FETCH;
                S_FETCH: begin
                    if (Mem_Ready_i) begin
                        state <= S_DECODE;
                    end else if (expired) begin
                        state     <= S_TRAP;
                        bus_err_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    case (OP_i)
                        OP_R, OP_I, OP_LUI: state <= S_EXEC;
                        OP_LOAD, OP_S:      state <= S_MEM_ADDR;
                        OP_B:               state <= S_BRANCH;
                        OP_JAL:             state <= S_JAL;
                        OP_JALR:            state <= S_JALR;
                        default: begin
                            state     <= S_TRAP;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                S_EXEC:     state <= S_ALU_WB;
                S_MEM_ADDR: state <= (OP_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: begin
                    if (Mem_Ready_i) begin
                        state <= S_MEM_WB;
                    end else if (expired) begin
                        state     <= S_TRAP;
                        bus_err_q <= 1'b1;
                    end
                end
                S_MEM_WR: begin
                    if (Mem_Ready_i) begin
                        state <= S_FETCH;
                    end else if (expired) begin
                        state     <= S_TRAP;
                        bus_err_q <= 1'b1;
                    end
                end
                S_ALU_WB, S_MEM_WB, S_BRANCH, S_JAL, S_JALR: state <= S_FETCH;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_INIT;
            endcase
        end
    end

    // Moore decode of datapath controls; fetch IR/PC loads and the store's done pulse wait for ready
    always_comb begin
        PC_Write_o   = 1'b0;
        Branch_o     = 1'b0;
        PC_Src_o     = 1'b0;
        I_or_D_o     = 1'b0;
        Mem_Read_o   = 1'b0;
        Mem_Write_o  = 1'b0;
        IR_Write_o   = 1'b0;
        Mem_to_Reg_o = WB_ALUOUT;
        Reg_Write_o  = 1'b0;
        ALU_Src_A_o  = SRC_A_PC;
        ALU_Src_B_o  = SRC_B_RS2;
        ALU_Op_o     = ALU_R;
        Instr_Done_o = 1'b0;
        case (state)
            S_FETCH: begin
                Mem_Read_o  = 1'b1;
                ALU_Src_B_o = SRC_B_FOUR;
                ALU_Op_o    = ALU_ADD;
                IR_Write_o  = Mem_Ready_i;
                PC_Write_o  = Mem_Ready_i;
            end
            S_DECODE: begin
                ALU_Src_A_o = SRC_A_OLDPC;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = ALU_ADD;
            end
            S_EXEC: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = (OP_i == OP_R) ? SRC_B_RS2 : SRC_B_IMM;
                ALU_Op_o    = (OP_i == OP_R) ? ALU_R : ((OP_i == OP_I) ? ALU_I : ALU_U);
            end
            S_ALU_WB: begin
                Reg_Write_o  = 1'b1;
                Instr_Done_o = 1'b1;
            end
            S_MEM_ADDR: begin
                ALU_Src_A_o = SRC_A_RS1;
                ALU_Src_B_o = SRC_B_IMM;
                ALU_Op_o    = (OP_i == OP_LOAD) ? ALU_ADD : ALU_S;
            end
            S_MEM_RD: begin
                I_or_D_o   = 1'b1;
                Mem_Read_o = 1'b1;
            end
            S_MEM_WB: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_MDR;
                Instr_Done_o = 1'b1;
            end
            S_MEM_WR: begin
                I_or_D_o     = 1'b1;
                Mem_Write_o  = 1'b1;
                Instr_Done_o = Mem_Ready_i;
            end
            S_BRANCH: begin
                ALU_Src_A_o  = SRC_A_RS1;
                ALU_Op_o     = ALU_B;
                Branch_o     = 1'b1;
                PC_Src_o     = 1'b1;
                Instr_Done_o = 1'b1;
            end
            S_JAL: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_PC;
                PC_Write_o   = 1'b1;
                PC_Src_o     = 1'b1;
                Instr_Done_o = 1'b1;
            end
            S_JALR: begin
                Reg_Write_o  = 1'b1;
                Mem_to_Reg_o = WB_PC;
                ALU_Src_A_o  = SRC_A_RS1;
                ALU_Src_B_o  = SRC_B_IMM;
                ALU_Op_o     = ALU_ADD;
                PC_Write_o   = 1'b1;
                Instr_Done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Illegal_o = illegal_q;
    assign Bus_Err_o = bus_err_q;
    assign State_o   = state;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for the multi-cycle sequencer: per-cycle state and full control-word checks.
// Latency: one check per clock, inputs applied 1 time unit after the rising edge.
// Backpressure: Mem_Ready_i driven directly from the step table.
module tb_multi_cycle_control;

    logic       clk;
    logic       reset;
    logic [6:0] OP;
    logic       ready;

    logic       PC_Write_o, Branch_o, PC_Src_o, I_or_D_o, Mem_Read_o, Mem_Write_o, IR_Write_o;
    logic [1:0] Mem_to_Reg_o;
    logic       Reg_Write_o;
    logic [1:0] ALU_Src_A_o, ALU_Src_B_o;
    logic [2:0] ALU_Op_o;
    logic       Instr_Done_o, Illegal_o, Bus_Err_o;
    logic [3:0] State_o;

    int vectors     = 0;
    int miscompares = 0;

    multi_cycle_control #(.TIMEOUT_CYCLES(16), .TIMER_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .OP_i         (OP),
        .Mem_Ready_i  (ready),
        .PC_Write_o   (PC_Write_o),
        .Branch_o     (Branch_o),
        .PC_Src_o     (PC_Src_o),
        .I_or_D_o     (I_or_D_o),
        .Mem_Read_o   (Mem_Read_o),
        .Mem_Write_o  (Mem_Write_o),
        .IR_Write_o   (IR_Write_o),
        .Mem_to_Reg_o (Mem_to_Reg_o),
        .Reg_Write_o  (Reg_Write_o),
        .ALU_Src_A_o  (ALU_Src_A_o),
        .ALU_Src_B_o  (ALU_Src_B_o),
        .ALU_Op_o     (ALU_Op_o),
        .Instr_Done_o (Instr_Done_o),
        .Illegal_o    (Illegal_o),
        .Bus_Err_o    (Bus_Err_o),
        .State_o      (State_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] obs_ctl;
    assign obs_ctl = {PC_Write_o, Branch_o, PC_Src_o, I_or_D_o, Mem_Read_o, Mem_Write_o, IR_Write_o,
                      Mem_to_Reg_o, Reg_Write_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o,
                      Instr_Done_o, Illegal_o, Bus_Err_o};

    // Packs a hand-written expected control word in the same field order as obs_ctl
    function automatic logic [19:0] ctl(input logic pcw, input logic br, input logic pcs, input logic iod,
                                        input logic mr, input logic mw, input logic irw, input logic [1:0] m2r,
                                        input logic rw, input logic [1:0] a, input logic [1:0] b,
                                        input logic [2:0] aop, input logic done, input logic ill,
                                        input logic be);
        return {pcw, br, pcs, iod, mr, mw, irw, m2r, rw, a, b, aop, done, ill, be};
    endfunction

    task automatic chk(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Apply inputs, check state and controls for this cycle, then advance one clock
    task automatic step(input string tag, input logic [6:0] op, input logic rdy,
                        input logic [3:0] st, input logic [19:0] c);
        OP    = op;
        ready = rdy;
        #1;
        chk({tag, ".state"}, {16'd0, State_o}, {16'd0, st});
        chk({tag, ".ctl"}, obs_ctl, c);
        @(posedge clk);
        #1;
    endtask

    logic [19:0] Z, F0, F1, DEC, EXR, EXI, EXU, AWB, MAL, MAS, MRD, MWB, MWR0, MWR1, BR, JL, JR, TRI, TRB;

    initial begin
        //      pcw br pcs iod mr mw irw m2r   rw a      b      aop     dn il be
        Z    = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        F0   = ctl(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b01, 3'b110, 0, 0, 0);
        F1   = ctl(1, 0, 0, 0, 1, 0, 1, 2'b00, 0, 2'b00, 2'b01, 3'b110, 0, 0, 0);
        DEC  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b10, 3'b110, 0, 0, 0);
        EXR  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0);
        EXI  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 3'b001, 0, 0, 0);
        EXU  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 3'b010, 0, 0, 0);
        AWB  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 3'b000, 1, 0, 0);
        MAL  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 3'b110, 0, 0, 0);
        MAS  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b10, 3'b101, 0, 0, 0);
        MRD  = ctl(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        MWB  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 3'b000, 1, 0, 0);
        MWR0 = ctl(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        MWR1 = ctl(0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 1, 0, 0);
        BR   = ctl(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00, 3'b011, 1, 0, 0);
        JL   = ctl(1, 0, 1, 0, 0, 0, 0, 2'b10, 1, 2'b00, 2'b00, 3'b000, 1, 0, 0);
        JR   = ctl(1, 0, 0, 0, 0, 0, 0, 2'b10, 1, 2'b01, 2'b10, 3'b110, 1, 0, 0);
        TRI  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 1, 0);
        TRB  = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 3'b000, 0, 0, 1);

        // Reset held across an edge
        reset = 1'b0;
        OP    = 7'h00;
        ready = 1'b0;
        @(posedge clk);
        #1;
        chk("reset.state", {16'd0, State_o}, 20'd0);
        chk("reset.ctl", obs_ctl, Z);
        reset = 1'b1;
        step("init", 7'h00, 1'b1, 4'd0, Z);

        // R-type, zero-wait: 1,2,3,4
        step("r.fetch",  7'h33, 1'b1, 4'd1, F1);
        step("r.decode", 7'h33, 1'b1, 4'd2, DEC);
        step("r.exec",   7'h33, 1'b1, 4'd3, EXR);
        step("r.wb",     7'h33, 1'b1, 4'd4, AWB);

        // LOAD with three wait cycles in MEM_RD (ready low in decode/addr is ignored)
        step("ld.fetch", 7'h03, 1'b1, 4'd1, F1);
        step("ld.decode",7'h03, 1'b0, 4'd2, DEC);
        step("ld.addr",  7'h03, 1'b0, 4'd5, MAL);
        for (int i = 0; i < 3; i++) step("ld.rd_wait", 7'h03, 1'b0, 4'd6, MRD);
        step("ld.rd_rdy",7'h03, 1'b1, 4'd6, MRD);
        step("ld.wb",    7'h03, 1'b1, 4'd7, MWB);

        // Store with one wait cycle; done only on ready
        step("st.fetch", 7'h23, 1'b1, 4'd1, F1);
        step("st.decode",7'h23, 1'b1, 4'd2, DEC);
        step("st.addr",  7'h23, 1'b1, 4'd5, MAS);
        step("st.wait",  7'h23, 1'b0, 4'd8, MWR0);
        step("st.rdy",   7'h23, 1'b1, 4'd8, MWR1);

        // I-logic and LUI
        step("i.fetch",  7'h13, 1'b1, 4'd1, F1);
        step("i.decode", 7'h13, 1'b1, 4'd2, DEC);
        step("i.exec",   7'h13, 1'b1, 4'd3, EXI);
        step("i.wb",     7'h13, 1'b1, 4'd4, AWB);
        step("u.fetch",  7'h37, 1'b1, 4'd1, F1);
        step("u.decode", 7'h37, 1'b1, 4'd2, DEC);
        step("u.exec",   7'h37, 1'b1, 4'd3, EXU);
        step("u.wb",     7'h37, 1'b1, 4'd4, AWB);

        // Branch, JAL, JALR
        step("b.fetch",  7'h63, 1'b1, 4'd1, F1);
        step("b.decode", 7'h63, 1'b1, 4'd2, DEC);
        step("b.branch", 7'h63, 1'b1, 4'd9, BR);
        step("j.fetch",  7'h6F, 1'b1, 4'd1, F1);
        step("j.decode", 7'h6F, 1'b1, 4'd2, DEC);
        step("j.jal",    7'h6F, 1'b1, 4'd10, JL);
        step("jr.fetch", 7'h67, 1'b1, 4'd1, F1);
        step("jr.decode",7'h67, 1'b1, 4'd2, DEC);
        step("jr.jalr",  7'h67, 1'b1, 4'd11, JR);

        // Fetch stalled 15 cycles, ready on the cycle the count would hit the limit: ready wins
        for (int i = 0; i < 15; i++) step("to.fetch_wait", 7'h13, 1'b0, 4'd1, F0);
        step("to.fetch_rdy", 7'h13, 1'b1, 4'd1, F1);
        step("to.decode",    7'h13, 1'b1, 4'd2, DEC);
        step("to.exec",      7'h13, 1'b1, 4'd3, EXI);
        step("to.wb",        7'h13, 1'b1, 4'd4, AWB);

        // Reset asserted while a load waits in MEM_RD
        step("mr.fetch", 7'h03, 1'b1, 4'd1, F1);
        step("mr.decode",7'h03, 1'b1, 4'd2, DEC);
        step("mr.addr",  7'h03, 1'b1, 4'd5, MAL);
        step("mr.rd",    7'h03, 1'b0, 4'd6, MRD);
        reset = 1'b0;
        #1;
        chk("mr.async_rst.state", {16'd0, State_o}, 20'd0);
        chk("mr.async_rst.ctl", obs_ctl, Z);
        @(posedge clk);
        #1;
        chk("mr.held_rst.ctl", obs_ctl, Z);
        reset = 1'b1;
        step("mr.init",  7'h7F, 1'b1, 4'd0, Z);
        step("mr.fetch0",7'h7F, 1'b0, 4'd1, F0);

        // Illegal opcode traps and stays, ready ignored
        step("ill.fetch", 7'h7F, 1'b1, 4'd1, F1);
        step("ill.decode",7'h7F, 1'b1, 4'd2, DEC);
        step("ill.trap0", 7'h7F, 1'b1, 4'd12, TRI);
        step("ill.trap1", 7'h33, 1'b0, 4'd12, TRI);
        step("ill.trap2", 7'h03, 1'b1, 4'd12, TRI);

        // Reset clears the sticky flag, then fetch stalls 16 cycles into a bus-error trap
        reset = 1'b0;
        #1;
        chk("be.rst.ctl", obs_ctl, Z);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("be.init", 7'h33, 1'b0, 4'd0, Z);
        for (int i = 0; i < 16; i++) step("be.fetch_wait", 7'h33, 1'b0, 4'd1, F0);
        step("be.trap0", 7'h33, 1'b1, 4'd12, TRB);
        step("be.trap1", 7'h33, 1'b0, 4'd12, TRB);
        step("be.trap2", 7'h03, 1'b1, 4'd12, TRB);
        reset = 1'b0;
        #1;
        chk("be.final_rst.state", {16'd0, State_o}, 20'd0);
        chk("be.final_rst.ctl", obs_ctl, Z);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
